// File: rtl/midi_pkg.sv
// midi_pkg: MIDI line rate, receiver state encoding and status nibbles shared with the parser.
package midi_pkg;
    localparam int MIDI_BAUD = 31250;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: one-clock tick every CLK_HZ/(BAUD*OVERSAMPLE) clocks, phase reset by clear.
module baud_tick_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int W   = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 MIDI-IN receiver with 16x oversampling, mid-bit sampling and framing checks.
module midi_uart_rx import midi_pkg::*; #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = MIDI_BAUD,
    parameter int OVERSAMPLE = 16,
    parameter int RX_INVERT  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic [7:0] midi_byte,
    output logic       midi_ready,
    output logic       frame_err,
    output logic       busy
);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
    rx_state_t  state, state_n;
    logic       rx_q1, rx_q2, rx_s, tick, clear, mid_hit, end_hit, ready_n, err_n;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_q1, rx_q2} <= 2'b11;
        else {rx_q1, rx_q2} <= {midi_rx, rx_q1};
    assign rx_s    = rx_q2 ^ 1'(RX_INVERT);
    assign clear   = state == IDLE && !rx_s;
    assign mid_hit = tick && tick_cnt == MID;
    assign end_hit = tick && tick_cnt == LAST;
    assign busy    = state != IDLE;
    baud_tick_gen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk(clk), .rst(rst), .clear(clear), .tick(tick)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        ready_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE:  state_n = rx_s ? IDLE : START;
            START: state_n = mid_hit ? (rx_s ? IDLE : DATA) : START;
            DATA:  state_n = (end_hit && bit_cnt == 3'd7) ? STOP : DATA;
            STOP: begin
                state_n = end_hit ? (rx_s ? IDLE : BREAK) : STOP;
                ready_n = end_hit && rx_s;
                err_n   = end_hit && !rx_s;
            end
            BREAK: state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end
    // Leaving START re-zeroes tick_cnt so data samples land 16 ticks apart at mid-bit.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            midi_byte  <= '0;
            midi_ready <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            midi_ready <= ready_n;
            frame_err  <= err_n;
            if (ready_n) midi_byte <= shreg;
            if (clear || (state == START && mid_hit)) tick_cnt <= '0;
            else if (tick) tick_cnt <= tick_cnt + 1'b1;
            if (clear) bit_cnt <= '0;
            else if (state == DATA && end_hit) bit_cnt <= bit_cnt + 1'b1;
            if (state == DATA && end_hit) shreg <= {rx_s, shreg[7:1]};
        end
endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: scoreboard bench; a faster clock keeps the 16x/DIV structure (DIV=25, 400 clk/bit).
module tb_midi_uart_rx;
    localparam int CLK_HZ = 12500000;
    localparam int BIT    = CLK_HZ / 31250;
    logic       clk = 1'b0, rst = 1'b1, midi_rx = 1'b1;
    logic [7:0] midi_byte;
    logic       midi_ready, frame_err, busy;
    int         errors = 0, checks = 0, cyc = 0, start_cyc = 0, ready_cyc = 0;
    int         err_seen = 0, ready_seen = 0;
    logic       ready_prev = 1'b0;
    logic [7:0] sb[$];

    midi_uart_rx #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst), .midi_rx(midi_rx), .midi_byte(midi_byte),
        .midi_ready(midi_ready), .frame_err(frame_err), .busy(busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (midi_ready || frame_err) check("ready_err_exclusive", int'(midi_ready & frame_err), 0);
            if (frame_err) err_seen++;
            if (midi_ready) begin
                ready_seen++;
                ready_cyc = cyc;
                check("ready_one_clock", int'(ready_prev), 0);
                check("busy_at_ready", int'(busy), 0);
                if (sb.size() == 0) check("unexpected_ready", int'(midi_byte), -1);
                else check("midi_byte", int'(midi_byte), int'(sb.pop_front()));
            end
        end
        ready_prev = midi_ready;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop, input logic push);
        if (push) sb.push_back(b);
        @(posedge clk);
        #1 midi_rx = 1'b0;
        start_cyc = cyc;
        idle(bclk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            idle(bclk);
        end
        midi_rx = stop;
        idle(bclk);
    endtask

    initial begin
        #2000000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle(5);
        check("rst_byte", int'(midi_byte), 0);
        check("rst_ready", int'(midi_ready), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        idle(20);
        // single byte, latency, busy behaviour
        send_byte(8'h90, BIT, 1'b1, 1'b1);
        check("latency_window", int'(ready_cyc - start_cyc >= BIT * 19 / 2 - 30 && ready_cyc - start_cyc <= BIT * 19 / 2 + 30), 1);
        check("busy_after_byte", int'(busy), 0);
        idle(BIT);
        // back-to-back, no idle gap
        send_byte(8'h90, BIT, 1'b1, 1'b1);
        send_byte(8'h3C, BIT, 1'b1, 1'b1);
        send_byte(8'h64, BIT, 1'b1, 1'b1);
        idle(BIT);
        check("b2b_ready_count", ready_seen, 4);
        check("b2b_no_err", err_seen, 0);
        // short low glitch
        midi_rx = 1'b0;
        idle(BIT / 4);
        midi_rx = 1'b1;
        idle(BIT * 5 / 8);
        check("glitch_busy", int'(busy), 0);
        check("glitch_ready_count", ready_seen, 4);
        check("glitch_err", err_seen, 0);
        // framing error followed by held-low break
        send_byte(8'h90, BIT, 1'b1, 1'b1);
        send_byte(8'h55, BIT, 1'b0, 1'b0);
        idle(BIT * 25 / 8);
        check("break_err_count", err_seen, 1);
        check("break_byte_kept", int'(midi_byte), 8'h90);
        check("break_busy", int'(busy), 1);
        midi_rx = 1'b1;
        idle(BIT);
        check("break_released", int'(busy), 0);
        send_byte(8'h80, BIT, 1'b1, 1'b1);
        idle(BIT);
        check("after_break_byte", int'(midi_byte), 8'h80);
        // asynchronous reset in the middle of bit 4
        @(posedge clk);
        #1 midi_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            midi_rx = (8'hC3 >> i) & 1;
            idle(BIT);
        end
        midi_rx = 1'b0;
        idle(BIT / 2);
        check("pre_rst_busy", int'(busy), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_byte", int'(midi_byte), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(midi_ready), 0);
        check("arst_err", int'(frame_err), 0);
        midi_rx = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(10);
        send_byte(8'h3C, BIT, 1'b1, 1'b1);
        idle(BIT);
        check("post_rst_byte", int'(midi_byte), 8'h3C);
        // rate tolerance
        send_byte(8'hA5, BIT * 97 / 100, 1'b1, 1'b1);
        idle(BIT);
        send_byte(8'hA5, BIT * 103 / 100, 1'b1, 1'b1);
        idle(BIT);
        check("final_ready_count", ready_seen, 9);
        check("final_err_count", err_seen, 1);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
